pwm_decoder: RTL and testbench
==============================

Name: pwm_decoder

Overview:
Receive-side counterpart of the motor PWM driver. It samples a two-phase PWM pair (A/B), identifies which phase is pulsing, and recovers the 8-bit duty cycle and the direction. Results are published once per completed PWM period. Used for loopback checking of the driver in hardware and for monitoring externally driven motor channels.

Parameters:
clk_hz, 25000000, system clock frequency in Hz
pwm_hz, 250, nominal PWM frequency in Hz
FILTER_LEN, 4, glitch-filter stability length in cycles; used only with the optional feature

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
pwm_inA  input  1  PWM phase A; asynchronous input
pwm_inB  input  1  PWM phase B; asynchronous input
duty_cycle  output  8  last measured duty cycle; 0..255
direction  output  1  0 = phase A pulsing, 1 = phase B pulsing
active  output  1  1 while periodic edges are being received
valid  output  1  one-cycle pulse when duty_cycle/direction update
fault  output  1  sticky flag: both phases seen high together

Behaviour:
- Derived constants:
  - PERIOD = clk_hz/pwm_hz.
  - DIV = PERIOD/256; an elaboration error is raised if DIV < 1.
  - TIMEOUT = 2*PERIOD.
- Input synchronisation:
  - Each input passes through a 2-flop synchroniser giving sA and sB.
  - A rising edge is detected from a registered copy of the synchronised signal.
- Reset (rst=0 at a clk edge):
  - duty_cycle=0, direction=0, active=0, valid=0, fault=0.
  - FSM goes to IDLE; all counters are cleared.
  - Reset mid-period discards the partial measurement.
- FSM states and transitions:
  - IDLE: waits for a rising edge on sA or sB. On the edge: ch <= 1 if B else 0; go to MEAS; no publish.
  - MEAS counters:
    - per_cnt increments every cycle.
    - While the current channel is high, the prescaler counts 0..DIV-1. On wrap, hi_ticks increments, saturating at 255.
  - MEAS, rising edge on either channel:
    - Publish duty_cycle <= hi_ticks, direction <= ch, active <= 1, valid <= 1.
    - Clear the counters; ch <= channel of the new edge.
    - An edge on the other channel is therefore a direction change; the just-closed period is attributed to the old channel.
  - MEAS, per_cnt reaches TIMEOUT-1 without an edge:
    - Publish duty_cycle <= 255 if the current channel is high, else 0.
    - direction <= ch, active <= 0, valid <= 1; go to IDLE.
    - Only one valid is issued per timeout.
  - Any state, sA & sB in the same cycle:
    - fault <= 1; active <= 0; go to FAULT; no valid.
    - In the same cycle as a rising edge, fault takes priority.
  - FAULT: stays here until reset; outputs hold their last values.
- Latency: valid is high on the 3rd clk edge after the raw input rising edge (2 sync stages + 1 edge register). The filter adds FILTER_LEN cycles.
- A 100% period (high for all PERIOD cycles) reports 255 through saturation. 0% or 100% static levels report via timeout.
- duty_cycle and direction change only in cycles where valid=1.

Optional Feature:
PWM_DEC_GLITCH_FILTER_EN
- Defined: after synchronisation, each channel passes through a filter. The filtered level changes only after the raw synchronised value has differed from it for FILTER_LEN consecutive cycles. Pulses shorter than FILTER_LEN are ignored. Latency increases by FILTER_LEN.
- Undefined: no filter; the synchronised signals feed the FSM directly; the FILTER_LEN parameter is ignored.

Test Plan:
(Bench parameters: clk_hz=25600, pwm_hz=100 -> PERIOD=256, DIV=1, TIMEOUT=512.)
1. Phase A: 128 high / 128 low for 3 periods, B=0 -> valid pulses on the 2nd and 3rd edges; duty_cycle=128, direction=0, active=1; no valid on the 1st edge.
2. Phase B: 64 high / 192 low for 3 periods -> duty_cycle=64, direction=1, each valid exactly 1 cycle wide.
3. One A edge, then A held high -> valid 512 cycles after the synchronised edge; duty_cycle=255, active=0. Repeat with A returning low after 10 cycles -> duty_cycle=0.
4. A at 128/128, then B rising while A is low -> valid with duty_cycle=128, direction=0; the next B period gives direction=1.
5. A and B both high for 1 cycle mid-period -> fault=1, active=0, no further valid despite continued edges; rst=0 for 1 cycle clears fault.
6. rst=0 at cycle 100 of an A period -> all outputs 0 next cycle; the first subsequent edge gives no valid. With PWM_DEC_GLITCH_FILTER_EN and FILTER_LEN=4, a 2-cycle B glitch is ignored (no state change).

Source files
------------

// File: rtl/pwm_decoder.sv
// Two-phase PWM receiver: recovers 8-bit duty, direction and activity from an A/B pair.
// Optional glitch filter on the synchronised inputs: define PWM_DEC_GLITCH_FILTER_EN.
module pwm_decoder #(
  parameter int clk_hz     = 25000000,
  parameter int pwm_hz     = 250,
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_inA,
  input  logic       pwm_inB,
  output logic [7:0] duty_cycle,
  output logic       direction,
  output logic       active,
  output logic       valid,
  output logic       fault
);

  localparam int PERIOD  = clk_hz / pwm_hz;
  localparam int DIV     = PERIOD / 256;
  localparam int TIMEOUT = 2 * PERIOD;
  localparam int PW      = $clog2(TIMEOUT);
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  // The edge cycle itself is a high cycle of the new channel, so counting starts one step in.
  localparam logic [DW-1:0] PRESC0 = (DIV == 1) ? '0 : DW'(1);
  localparam logic [7:0]    HI0    = (DIV == 1) ? 8'd1 : 8'd0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MEAS  = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  if (DIV < 1 || FILTER_LEN < 1) begin : g_param_chk
    $error("pwm_decoder: clk_hz/pwm_hz must be >= 256 and FILTER_LEN >= 1");
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  logic a_p0, a_p1, b_p0, b_p1;
  logic fa, fb, fa_p2, fb_p2;
  logic rise_a, rise_b, lvl;
  logic [1:0]    state;
  logic          ch;
  logic [PW-1:0] per_cnt;
  logic [DW-1:0] presc;
  logic [7:0]    hi_ticks;

  // p0/p1: synchroniser stages; left unreset so a level held across reset is not seen as an edge
  always_ff @(posedge clk) begin
    a_p0 <= pwm_inA;
    a_p1 <= a_p0;
    b_p0 <= pwm_inB;
    b_p1 <= b_p0;
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] fa_cnt, fb_cnt;

  always_ff @(posedge clk) begin
    if (a_p1 == fa) begin
      fa_cnt <= '0;
    end else if (fa_cnt == FW'(FILTER_LEN - 1)) begin
      fa     <= a_p1;
      fa_cnt <= '0;
    end else begin
      fa_cnt <= fa_cnt + FW'(1);
    end
    if (b_p1 == fb) begin
      fb_cnt <= '0;
    end else if (fb_cnt == FW'(FILTER_LEN - 1)) begin
      fb     <= b_p1;
      fb_cnt <= '0;
    end else begin
      fb_cnt <= fb_cnt + FW'(1);
    end
  end
`else
  assign fa = a_p1;
  assign fb = b_p1;
`endif

  // p2: registered copy of the FSM-side level for rising-edge detection
  always_ff @(posedge clk) begin
    fa_p2 <= fa;
    fb_p2 <= fb;
  end

  assign rise_a = fa & ~fa_p2;
  assign rise_b = fb & ~fb_p2;
  assign lvl    = ch ? fb : fa;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ch         <= 1'b0;
      per_cnt    <= '0;
      presc      <= '0;
      hi_ticks   <= '0;
      duty_cycle <= '0;
      direction  <= 1'b0;
      active     <= 1'b0;
      valid      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state != FAULT && fa && fb) begin
        fault  <= 1'b1;
        active <= 1'b0;
        state  <= FAULT;
      end else begin
        case (state)
          IDLE: begin
            if (rise_a || rise_b) begin
              state    <= MEAS;
              ch       <= rise_b;
              per_cnt  <= PW'(1);
              presc    <= PRESC0;
              hi_ticks <= HI0;
            end
          end
          MEAS: begin
            if (rise_a || rise_b) begin
              duty_cycle <= hi_ticks;
              direction  <= ch;
              active     <= 1'b1;
              valid      <= 1'b1;
              ch         <= rise_b;
              per_cnt    <= PW'(1);
              presc      <= PRESC0;
              hi_ticks   <= HI0;
            end else if (per_cnt == PW'(TIMEOUT - 1)) begin
              duty_cycle <= lvl ? 8'hff : 8'h00;
              direction  <= ch;
              active     <= 1'b0;
              valid      <= 1'b1;
              state      <= IDLE;
              per_cnt    <= '0;
              presc      <= '0;
              hi_ticks   <= '0;
            end else begin
              per_cnt <= per_cnt + PW'(1);
              if (lvl) begin
                if (presc == DW'(DIV - 1)) begin
                  presc    <= '0;
                  hi_ticks <= sat_inc(hi_ticks);
                end else begin
                  presc <= presc + DW'(1);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: cycle-level reference model, vector table and hand-written corner sequences.
module tb_pwm_decoder;
  localparam int CLK_HZ  = 25600;
  localparam int PWM_HZ  = 100;
  localparam int FLEN    = 4;
  localparam int PERIOD  = CLK_HZ / PWM_HZ;
  localparam int TIMEOUT = 2 * PERIOD;
`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int FL = FLEN;
`else
  localparam int FL = 0;
`endif

  logic clk = 1'b0, rst = 1'b0, pin_a = 1'b0, pin_b = 1'b0;
  logic [7:0] duty_cycle;
  logic direction, active, valid, fault;

  always #5 clk = ~clk;

  pwm_decoder #(.clk_hz(CLK_HZ), .pwm_hz(PWM_HZ), .FILTER_LEN(FLEN)) dut (
    .clk(clk), .rst(rst), .pwm_inA(pin_a), .pwm_inB(pin_b),
    .duty_cycle(duty_cycle), .direction(direction), .active(active),
    .valid(valid), .fault(fault)
  );

  int total = 0, bad = 0;
  int vcount = 0, wide = 0;
  logic prev_v = 1'b0;
  logic [7:0] last_duty = '0;
  logic last_dir = 1'b0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: expected outputs for the next cycle, from spec-level rules
  int         cyc = 0;
  int         m_mode = 0;        // 0 idle, 1 measuring, 2 faulted
  bit         m_ch = 1'b0;
  int         m_edge_t = 0;
  int         m_high = 0;
  logic [1:0] rh_a = '0, rh_b = '0;
  logic       fpa = 1'b0, fpb = 1'b0;
  logic [FLEN-1:0] sh_a = '0, sh_b = '0;
  logic       fl_a = 1'b0, fl_b = 1'b0;
  logic [7:0] e_duty = '0;
  logic       e_dir = 1'b0, e_active = 1'b0, e_valid = 1'b0, e_fault = 1'b0;

  always @(negedge clk) begin
    logic sa, sb, fa, fb, ra, rb, lvl;
    if (chk_en) begin
      check("model", int'({valid, fault, active, direction, duty_cycle}),
            int'({e_valid, e_fault, e_active, e_dir, e_duty}));
      if (valid) begin
        vcount++;
        last_duty = duty_cycle;
        last_dir  = direction;
        if (prev_v) wide++;
      end
      prev_v = valid;
    end
    sa = rh_a[1];
    sb = rh_b[1];
    rh_a = {rh_a[0], pin_a};
    rh_b = {rh_b[0], pin_b};
`ifdef PWM_DEC_GLITCH_FILTER_EN
    fa = fl_a;
    fb = fl_b;
    sh_a = {sh_a[FLEN-2:0], sa};
    sh_b = {sh_b[FLEN-2:0], sb};
    if (sh_a == {FLEN{~fl_a}}) fl_a = ~fl_a;
    if (sh_b == {FLEN{~fl_b}}) fl_b = ~fl_b;
`else
    fa = sa;
    fb = sb;
`endif
    ra = fa & ~fpa;
    rb = fb & ~fpb;
    fpa = fa;
    fpb = fb;
    e_valid = 1'b0;
    if (!rst) begin
      e_duty = '0; e_dir = 1'b0; e_active = 1'b0; e_fault = 1'b0; m_mode = 0;
    end else if (m_mode == 2) begin
      e_valid = 1'b0;
    end else if (fa && fb) begin
      e_fault = 1'b1; e_active = 1'b0; m_mode = 2;
    end else begin
      lvl = m_ch ? fb : fa;
      if (ra || rb) begin
        if (m_mode == 1) begin
          e_duty = (m_high > 255) ? 8'd255 : 8'(m_high);
          e_dir = m_ch; e_active = 1'b1; e_valid = 1'b1;
        end
        m_mode = 1; m_ch = rb; m_edge_t = cyc; m_high = 1;
      end else if (m_mode == 1) begin
        if (cyc - m_edge_t == TIMEOUT - 1) begin
          e_duty = lvl ? 8'd255 : 8'd0;
          e_dir = m_ch; e_active = 1'b0; e_valid = 1'b1; m_mode = 0;
        end else if (lvl) begin
          m_high++;
        end
      end
    end
    cyc++;
  end

  task automatic tick(input logic a, input logic b);
    pin_a = a;
    pin_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic period(input bit ch, input int hi, input int per);
    for (int i = 0; i < per; i++) tick(!ch && i < hi, ch && i < hi);
  endtask

  task automatic hold_until_valid(input logic a, input logic b, input int budget, output int n);
    int v0;
    v0 = vcount;
    n = 0;
    while (vcount == v0 && n < budget) begin
      tick(a, b);
      n++;
    end
    if (vcount == v0) check("valid-wait-expired", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".duty"}, duty_cycle, 0);
    check({tag, ".dir"}, direction, 0);
    check({tag, ".active"}, active, 0);
    check({tag, ".valid"}, valid, 0);
    check({tag, ".fault"}, fault, 0);
  endtask

  typedef struct {
    bit ch;
    int hi;
    int n;
    int exp_valids;
    int exp_duty;
    bit exp_dir;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int v0, n, n2, hi, per;
    bit ch;

    #(800000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int v0, n, n2, hi, per;
    bit ch;
    tbl = '{
      '{0, 128, 3, 2, 128, 0},
      '{1,  64, 1, 1, 128, 0},
      '{1,  64, 3, 3,  64, 1},
      '{0, 200, 2, 2, 200, 0},
      '{0, 250, 2, 2, 250, 0},
      '{0, 256, 1, 1, 250, 0},
      '{1,  64, 1, 1, 255, 0},
      '{0,   5, 2, 2,   5, 0}
    };

    tick(0, 0);
    chk_en = 1'b1;
    repeat (4) tick(0, 0);
    check_zero("reset");
    rst = 1'b1;
    repeat (5) tick(0, 0);

    for (int k = 0; k < 8; k++) begin
      v0 = vcount;
      for (int p = 0; p < tbl[k].n; p++) period(tbl[k].ch, tbl[k].hi, PERIOD);
      check($sformatf("tbl%0d.valids", k), vcount - v0, tbl[k].exp_valids);
      check($sformatf("tbl%0d.duty", k), last_duty, tbl[k].exp_duty);
      check($sformatf("tbl%0d.dir", k), last_dir, tbl[k].exp_dir);
      check($sformatf("tbl%0d.active", k), active, 1);
    end
    check("valid-width", wide, 0);

    // Static low closes the measurement via timeout
    hold_until_valid(0, 0, 2000, n);
    check("to-low.duty", duty_cycle, 0);
    check("to-low.active", active, 0);
    repeat (5) tick(0, 0);

    // One edge then held high: timeout reports 255
    hold_until_valid(1, 0, 2000, n);
    check("to-high.latency", n, TIMEOUT + 3 + FL);
    check("to-high.duty", duty_cycle, 255);
    check("to-high.active", active, 0);
    check("to-high.dir", direction, 0);
    repeat (20) tick(0, 0);

    // Short pulse then static low
    repeat (10) tick(1, 0);
    hold_until_valid(0, 0, 2000, n2);
    check("to-pulse.latency", 10 + n2, TIMEOUT + 3 + FL);
    check("to-pulse.duty", duty_cycle, 0);
    check("to-pulse.active", active, 0);
    repeat (5) tick(0, 0);

    for (int r = 0; r < 40; r++) begin
      ch  = 1'($urandom % 2);
      hi  = $urandom_range(5, 250);
      per = ($urandom % 8 == 0) ? $urandom_range(520, 700) : $urandom_range(hi + 5, 300);
      period(ch, hi, per);
    end
    check("rand.valid-width", wide, 0);

    // Overlapping phases latch fault until reset
    period(0, 128, PERIOD);
    period(0, 128, PERIOD);
    v0 = vcount;
    for (int i = 0; i < PERIOD; i++) begin
      tick(i < 128, i >= 50 && i < 51 + FL);
      if (i == 40) v0 = vcount;
    end
    period(0, 128, PERIOD);
    period(0, 128, PERIOD);
    check("fault.flag", fault, 1);
    check("fault.active", active, 0);
    check("fault.no-valid", vcount - v0, 0);
    rst = 1'b0;
    tick(0, 0);
    rst = 1'b1;
    check_zero("fault-clear");
    repeat (5) tick(0, 0);

    // Reset mid-period discards the partial measurement
    period(0, 128, PERIOD);
    period(0, 128, PERIOD);
    for (int i = 0; i < 100; i++) tick(1, 0);
    rst = 1'b0;
    tick(1, 0);
    rst = 1'b1;
    check_zero("mid-reset");
    for (int i = 101; i < PERIOD; i++) tick(i < 128, 0);
    v0 = vcount;
    period(0, 128, PERIOD);
    check("post-reset.no-valid", vcount - v0, 0);
    period(0, 128, PERIOD);
    check("post-reset.valids", vcount - v0, 1);
    check("post-reset.duty", last_duty, 128);

`ifdef PWM_DEC_GLITCH_FILTER_EN
    v0 = vcount;
    for (int i = 0; i < PERIOD; i++) tick(i < 128, i == 150 || i == 151);
    period(0, 128, PERIOD);
    check("glitch.valids", vcount - v0, 2);
    check("glitch.dir", last_dir, 0);
    check("glitch.duty", last_duty, 128);
    check("glitch.fault", fault, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
